mips_data_mem_responder: RTL and testbench

Responder end of the MIPS core's data-memory interface: accepts the core's `MemRead`/`MemWrite` requests and serves them from an internal word array after a fixed, parameterised wait. It returns read data with a one-cycle `Ready` pulse, which the core uses as its stall release. It sits beside the core top level on the same clock and replaces the zero-latency data memory. Misaligned and conflicting requests are flagged, not silently serviced.

---
 rtl/mips_mem_pkg.sv | 15 +
 rtl/mips_word_ram.sv | 29 ++
 rtl/mips_data_mem_responder.sv | 118 +++++++++++
 tb/tb_mips_data_mem_responder.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS data-memory responder.
// Imported by the word RAM and the responder FSM.
package mips_mem_pkg;

  localparam int WORD_W      = 32;
  localparam int LATENCY_MAX = 15;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mips_word_ram.sv
// Synchronous single-port word RAM with a registered,
// enable-gated read port that holds its value between reads.
module mips_word_ram
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] index,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     rdata
);

  logic [WORD_W-1:0] mem [2**DEPTH_LOG2];

  // Contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (we) mem[index] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[index];
  end

endmodule

// File: rtl/mips_data_mem_responder.sv
// Fixed-latency data-memory responder for the MIPS core.
// Serves MemRead/MemWrite with a one-cycle Ready and an Err flag.
module mips_data_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [WORD_W-1:0] Addr,
  input  logic [WORD_W-1:0] WriteData,
  output logic [WORD_W-1:0] ReadData,
  output logic              Ready,
  output logic              Err
);

  localparam int AW = DEPTH_LOG2 + 2;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [AW-1:0]     addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic              rd_q;
  logic              wr_q;
  logic              err_q;

  logic              req;
  logic              idle;
  logic              bad;
  logic [AW-1:0]     cur_addr;
  logic [WORD_W-1:0] cur_wdata;
  logic              cur_rd;
  logic              cur_wr;
  logic              cur_err;
  logic              enter_done;
  logic              we;
  logic              re;
  logic              unused_addr;

  assign req  = MemRead | MemWrite;
  assign idle = (state == IDLE);
  assign bad  = (Addr[1:0] != 2'b00) | (MemRead & MemWrite);

  assign unused_addr = ^Addr[WORD_W-1:AW];

  // With LATENCY=1 the commit happens straight from IDLE on live inputs.
  assign cur_addr  = idle ? Addr[AW-1:0] : addr_q;
  assign cur_wdata = idle ? WriteData : wdata_q;
  assign cur_rd    = idle ? MemRead : rd_q;
  assign cur_wr    = idle ? MemWrite : wr_q;
  assign cur_err   = idle ? bad : err_q;

  always_comb begin
    enter_done = 1'b0;
    if (!Rst) begin
      unique case (state)
        IDLE:    enter_done = req && (LATENCY == 1);
        WAIT:    enter_done = (cnt <= CNT_W'(1));
        default: enter_done = 1'b0;
      endcase
    end
  end

  assign we = enter_done & cur_wr & ~cur_err;
  assign re = enter_done & cur_rd & ~cur_err;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            addr_q  <= Addr[AW-1:0];
            wdata_q <= WriteData;
            rd_q    <= MemRead;
            wr_q    <= MemWrite;
            err_q   <= bad;
            cnt     <= CNT_LOAD;
            state   <= (LATENCY == 1) ? DONE : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt <= CNT_W'(1)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign Ready = (state == DONE);
  assign Err   = (state == DONE) & err_q;

  mips_word_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk  (Clk),
    .rst  (Rst),
    .we   (we),
    .re   (re),
    .index(cur_addr[AW-1:2]),
    .wdata(cur_wdata),
    .rdata(ReadData)
  );

endmodule

// File: tb/tb_mips_data_mem_responder.sv
// Scoreboard bench for mips_data_mem_responder at LATENCY 2,
// with LATENCY 1 and 5 copies for the Ready timing sweep.
module tb_mips_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic [31:0] rdata2, rdata1, rdata5;
  logic        ready2, ready1, ready5;
  logic        err2, err1, err5;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    int          cyc;
    logic        err;
    logic        chk;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mips_data_mem_responder #(.DEPTH_LOG2(10), .LATENCY(2)) dut2 (
    .Clk(clk), .Rst(rst), .MemRead(mem_read), .MemWrite(mem_write),
    .Addr(addr), .WriteData(wdata), .ReadData(rdata2),
    .Ready(ready2), .Err(err2)
  );

  mips_data_mem_responder #(.DEPTH_LOG2(10), .LATENCY(1)) dut1 (
    .Clk(clk), .Rst(rst), .MemRead(mem_read), .MemWrite(mem_write),
    .Addr(addr), .WriteData(wdata), .ReadData(rdata1),
    .Ready(ready1), .Err(err1)
  );

  mips_data_mem_responder #(.DEPTH_LOG2(10), .LATENCY(5)) dut5 (
    .Clk(clk), .Rst(rst), .MemRead(mem_read), .MemWrite(mem_write),
    .Addr(addr), .WriteData(wdata), .ReadData(rdata5),
    .Ready(ready5), .Err(err5)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (ready2 === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_ready", 32'(ready2), 32'd0);
      end else begin
        e = sb.pop_front();
        check("ready_cycle", cyc, e.cyc);
        check("err", 32'(err2), 32'(e.err));
        if (e.chk) check("read_data", rdata2, e.data);
      end
    end
  end

  task automatic xact(input logic rd, input logic wr,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic e_err, input logic e_chk,
                      input logic [31:0] e_data);
    bit got;
    @(posedge clk);
    #1;
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    wdata     = d;
    sb.push_back(exp_t'{cyc + 2, e_err, e_chk, e_data});
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ready2 === 1'b1) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      check("timeout", 32'd0, 32'd1);
      sb.delete();
    end
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    int t;
    rst       = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    addr      = '0;
    wdata     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(ready2), 32'd0);
    check("rst_err", 32'(err2), 32'd0);
    check("rst_rdata", rdata2, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    xact(0, 1, 32'h40, 32'hDEADBEEF, 0, 0, 32'h0);
    xact(1, 0, 32'h40, 32'h0, 0, 1, 32'hDEADBEEF);
    xact(0, 1, 32'h80, 32'h5555AAAA, 0, 0, 32'h0);

    xact(0, 1, 32'h1004, 32'h11111111, 0, 0, 32'h0);
    xact(1, 0, 32'h0004, 32'h0, 0, 1, 32'h11111111);

    xact(0, 1, 32'h100, 32'h12345678, 0, 0, 32'h0);
    xact(1, 0, 32'h100, 32'h0, 0, 1, 32'h12345678);
    xact(1, 0, 32'h42, 32'h0, 1, 1, 32'h12345678);
    xact(1, 1, 32'h40, 32'h99999999, 1, 1, 32'h12345678);
    xact(1, 0, 32'h40, 32'h0, 0, 1, 32'hDEADBEEF);

    // Reset lands on the cycle that would commit the write.
    @(posedge clk);
    #1;
    mem_write = 1'b1;
    addr      = 32'h80;
    wdata     = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    rst       = 1'b1;
    mem_write = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ready", 32'(ready2), 32'd0);
    check("midrst_err", 32'(err2), 32'd0);
    check("midrst_rdata", rdata2, 32'd0);
    repeat (6) @(posedge clk);
    xact(1, 0, 32'h80, 32'h0, 0, 1, 32'h5555AAAA);

    // Latency sweep with the request withdrawn after one cycle.
    repeat (20) @(posedge clk);
    #1;
    mem_read = 1'b1;
    addr     = 32'h40;
    t        = cyc;
    sb.push_back(exp_t'{t + 2, 1'b0, 1'b1, 32'hDEADBEEF});
    @(posedge clk);
    #1;
    mem_read = 1'b0;
    addr     = 32'h80;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check($sformatf("lat1_ready_k%0d", k), 32'(ready1),
            32'(k == 1));
      check($sformatf("lat5_ready_k%0d", k), 32'(ready5),
            32'(k == 5));
    end
    repeat (4) @(posedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
